peripheral_system_multi_timer: RTL and testbench

PERIPHERAL_SYSTEM_MULTI_TIMER -- requirements
Module: peripheral_system_multi_timer

---
 rtl/peripheral_system_timer_pkg.sv | 23 ++
 rtl/peripheral_system_timer_channel.sv | 124 ++++++++++++
 rtl/peripheral_system_multi_timer.sv | 83 ++++++++
 tb/tb_peripheral_system_multi_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_system_timer_pkg.sv
// Shared register map for the multi-channel timer: register offsets,
// STATUS/CONTROL bit positions and the prescaler field.
package peripheral_system_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_e;

  localparam int ST_TO_BIT     = 0;
  localparam int ST_RUN_BIT    = 1;

  localparam int CTL_ITO_BIT   = 0;
  localparam int CTL_CONT_BIT  = 1;
  localparam int CTL_START_BIT = 2;
  localparam int CTL_STOP_BIT  = 3;
  localparam int CTL_PRESC_LSB = 8;
  localparam int CTL_PRESC_MSB = 15;
  localparam int PRESC_W       = CTL_PRESC_MSB - CTL_PRESC_LSB + 1;

endpackage

// File: rtl/peripheral_system_timer_channel.sv
// One timer channel: prescaled down-counter with RUN/TO state and its
// CONTROL, PERIOD and SNAP registers. Read data is combinational; the top registers it.
module peripheral_system_timer_channel
  import peripheral_system_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 499
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
  logic               reload_q, reload_d;
  logic               wr_status_s, wr_ctrl_s, wr_period_s, wr_snap_s;
  logic               start_s, stop_s, tick_s, expire_s;

  // Write decode; >= keeps the prescaler sane if PRESC is lowered mid-count.
  always_comb begin
    wr_status_s = wr_en && (reg_sel == REG_STATUS);
    wr_ctrl_s   = wr_en && (reg_sel == REG_CONTROL);
    wr_period_s = wr_en && (reg_sel == REG_PERIOD);
    wr_snap_s   = wr_en && (reg_sel == REG_SNAP);
    start_s     = wr_ctrl_s && wdata[CTL_START_BIT];
    stop_s      = wr_ctrl_s && wdata[CTL_STOP_BIT];
    tick_s      = run_q && (pcnt_q >= presc_q);
    expire_s    = tick_s && (cnt_q == {CNT_W{1'b0}});
  end

  // Next-state logic for counter, prescaler and control/status state.
  always_comb begin
    if (wr_period_s || stop_s) run_d = 1'b0;
    else if (start_s)          run_d = 1'b1;
    else if (expire_s)         run_d = cont_q;
    else                       run_d = run_q;

    if (expire_s)         to_d = 1'b1;
    else if (wr_status_s) to_d = 1'b0;
    else                  to_d = to_q;

    if (reload_q || expire_s) cnt_d = period_q;
    else if (tick_s)          cnt_d = cnt_q - CNT_W'(1);
    else                      cnt_d = cnt_q;

    if (start_s || wr_period_s || tick_s) pcnt_d = {PRESC_W{1'b0}};
    else if (run_q)                       pcnt_d = pcnt_q + PRESC_W'(1);
    else                                  pcnt_d = pcnt_q;

    if (wr_period_s) period_d = wdata[CNT_W-1:0];
    else             period_d = period_q;
    reload_d = wr_period_s;

    if (wr_ctrl_s) begin
      ito_d   = wdata[CTL_ITO_BIT];
      cont_d  = wdata[CTL_CONT_BIT];
      presc_d = wdata[CTL_PRESC_MSB:CTL_PRESC_LSB];
    end else begin
      ito_d   = ito_q;
      cont_d  = cont_q;
      presc_d = presc_q;
    end

    if (wr_snap_s) snap_d = cnt_q;
    else           snap_d = snap_q;
  end

  // Register read view.
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[ST_RUN_BIT] = run_q;
        rd_data[ST_TO_BIT]  = to_q;
      end
      REG_CONTROL: begin
        rd_data[CTL_ITO_BIT]                 = ito_q;
        rd_data[CTL_CONT_BIT]                = cont_q;
        rd_data[CTL_PRESC_MSB:CTL_PRESC_LSB] = presc_q;
      end
      REG_PERIOD: rd_data[CNT_W-1:0] = period_q;
      REG_SNAP:   rd_data[CNT_W-1:0] = snap_q;
      default:    rd_data = 32'd0;
    endcase
  end

  assign irq = to_q & ito_q;

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= RST_CNT;
      period_q <= RST_CNT;
      snap_q   <= {CNT_W{1'b0}};
      presc_q  <= {PRESC_W{1'b0}};
      pcnt_q   <= {PRESC_W{1'b0}};
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      run_q    <= run_d;
      to_q     <= to_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/peripheral_system_multi_timer.sv
// Avalon-MM multi-channel timer: address decode, registered read mux and
// registered interrupt outputs around NUM_CH independent channels.
module peripheral_system_multi_timer
  import peripheral_system_timer_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  CNT_W        = 32,
  parameter int  RESET_PERIOD = 499,
  localparam int AW           = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CHW-1:0]    ch_s;
  logic [NUM_CH-1:0] ch_hit_s, wr_en_s, irq_s;
  logic [31:0]       ch_rd_s [NUM_CH];
  logic [31:0]       readdata_q, readdata_d;
  logic [NUM_CH-1:0] irq_vec_q, irq_vec_d;
  logic              irq_q, irq_d;

  if (NUM_CH > 1) begin : g_multi
    assign ch_s = address[AW-1:2];
  end else begin : g_single
    assign ch_s = 1'b0;
  end

  // Channel indices at or above NUM_CH match no hit bit, so they read 0 and ignore writes.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_hit_s[i] = (ch_s == CHW'(i));
    assign wr_en_s[i]  = chipselect && !write_n && ch_hit_s[i];

    peripheral_system_timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en_s[i]),
      .reg_sel (address[1:0]),
      .wdata   (writedata),
      .rd_data (ch_rd_s[i]),
      .irq     (irq_s[i])
    );
  end

  // Read mux and interrupt aggregation.
  always_comb begin
    readdata_d = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      readdata_d = readdata_d | (ch_rd_s[i] & {32{ch_hit_s[i]}});
    end
    irq_vec_d = irq_s;
    irq_d     = |irq_s;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 32'd0;
      irq_vec_q  <= {NUM_CH{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_vec_q  <= irq_vec_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = irq_vec_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_peripheral_system_multi_timer.sv
// Scoreboard bench for the multi-channel timer: a 4x32-bit instance and a
// 2x8-bit instance for the narrow-counter wrap case.
module tb_peripheral_system_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  addr_a;
  logic [2:0]  addr_b;
  logic        cs_a, wn_a, cs_b, wn_b;
  logic [31:0] wd_a, wd_b, rd_a, rd_b;
  logic        irq_a, irq_b;
  logic [3:0]  irqv_a;
  logic [1:0]  irqv_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  string       name_q [$];

  always #5 clk = ~clk;

  peripheral_system_multi_timer #(.NUM_CH(4), .CNT_W(32), .RESET_PERIOD(499)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(addr_a), .chipselect(cs_a), .write_n(wn_a),
    .writedata(wd_a), .readdata(rd_a), .irq(irq_a), .irq_vec(irqv_a)
  );

  peripheral_system_multi_timer #(.NUM_CH(2), .CNT_W(8), .RESET_PERIOD(499)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(addr_b), .chipselect(cs_b), .write_n(wn_b),
    .writedata(wd_b), .readdata(rd_b), .irq(irq_b), .irq_vec(irqv_b)
  );

  task automatic bus_write(input int dev, input int ch, input int rsel, input logic [31:0] data);
    if (dev == 0) begin
      addr_a = 4'(ch * 4 + rsel); cs_a = 1'b1; wn_a = 1'b0; wd_a = data;
    end else begin
      addr_b = 3'(ch * 4 + rsel); cs_b = 1'b1; wn_b = 1'b0; wd_b = data;
    end
    @(posedge clk); #1;
    cs_a = 1'b0; wn_a = 1'b1; cs_b = 1'b0; wn_b = 1'b1;
  endtask

  // Pushes the expected value, then records what the DUT returns a clock later.
  task automatic bus_read(input int dev, input int ch, input int rsel, input logic [31:0] exp, input string nm);
    if (dev == 0) addr_a = 4'(ch * 4 + rsel);
    else          addr_b = 3'(ch * 4 + rsel);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    got_q.push_back((dev == 0) ? rd_a : rd_b);
  endtask

  task automatic test_reset();
    logic [31:0] e, g; string n;
    reset_n = 1'b0; cs_a = 1'b0; wn_a = 1'b1; addr_a = 4'd0; wd_a = 32'd0;
    cs_b = 1'b0; wn_b = 1'b1; addr_b = 3'd0; wd_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rd_a !== 32'd0) begin bad++; $display("FAIL rst_readdata: got=%h want=0", rd_a); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL rst_irq: got=%b want=0", irq_a); end
    total++; if (irqv_a !== 4'd0) begin bad++; $display("FAIL rst_irq_vec: got=%b want=0000", irqv_a); end
    reset_n = 1'b1;
    bus_write(0, 3, 2, 32'd7);
    bus_read(0, 3, 2, 32'd7, "first_write_after_reset");
    bus_read(0, 0, 2, 32'd499, "rst_period_ch0");
    bus_read(0, 2, 0, 32'd0, "rst_status_ch2");
    bus_read(0, 1, 1, 32'd0, "rst_control_ch1");
    bus_read(1, 1, 2, 32'h0000_00F3, "rst_period_8bit");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] e, g; string n; logic want;
    bus_write(0, 2, 2, 32'd5);
    bus_write(0, 2, 1, 32'h7);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      want = (i == 7);
      total++; if (irqv_a[2] !== want) begin bad++; $display("FAIL cont_first_irq clk%0d: got=%b want=%b", i, irqv_a[2], want); end
    end
    bus_write(0, 2, 0, 32'd0);
    for (int i = 9; i <= 13; i++) begin
      @(posedge clk); #1;
      want = (i == 13);
      total++; if (irqv_a[2] !== want) begin bad++; $display("FAIL cont_reperiod clk%0d: got=%b want=%b", i, irqv_a[2], want); end
    end
    repeat (4) @(posedge clk);
    #1;
    bus_write(0, 2, 0, 32'd0);
    bus_read(0, 2, 0, 32'h3, "clear_on_timeout_status");
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL clear_on_timeout_irq: got=%b want=1", irq_a); end
    bus_write(0, 2, 1, 32'h8);
    bus_write(0, 2, 0, 32'd0);
    bus_read(0, 2, 0, 32'h0, "cont_stopped_status");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] e, g; string n;
    bus_write(0, 0, 2, 32'd3);
    bus_write(0, 0, 1, 32'h5);
    repeat (10) @(posedge clk);
    #1;
    bus_read(0, 0, 0, 32'h1, "oneshot_status");
    total++; if (irqv_a[0] !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got=%b want=1", irqv_a[0]); end
    bus_write(0, 0, 0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    bus_read(0, 0, 0, 32'h0, "oneshot_no_second_to");
    bus_write(0, 0, 3, 32'd0);
    bus_read(0, 0, 3, 32'd3, "oneshot_snap_reloaded");
    bus_read(0, 0, 2, 32'd3, "oneshot_period");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] e, g; string n;
    bus_write(0, 1, 2, 32'd10);
    bus_write(0, 1, 1, 32'h304);
    repeat (8) @(posedge clk);
    #1;
    bus_write(0, 1, 3, 32'd0);
    bus_read(0, 1, 3, 32'd8, "presc_snap_after_8");
    repeat (2) @(posedge clk);
    #1;
    bus_write(0, 1, 3, 32'd0);
    bus_read(0, 1, 3, 32'd7, "presc_snap_next");
    @(posedge clk); #1;
    bus_write(0, 1, 3, 32'd0);
    bus_read(0, 1, 3, 32'd7, "snap_on_tick_predec");
    bus_read(0, 1, 1, 32'h300, "presc_control_readback");
    bus_write(0, 1, 1, 32'h8);
    bus_read(0, 1, 0, 32'h0, "presc_stopped_status");
    repeat (8) @(posedge clk);
    #1;
    bus_write(0, 1, 3, 32'd0);
    bus_read(0, 1, 3, 32'd6, "stopped_counter_holds");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_start_stop_period();
    logic [31:0] e, g; string n;
    bus_write(0, 3, 1, 32'hC);
    bus_read(0, 3, 0, 32'h0, "start_stop_same_write");
    bus_write(0, 3, 1, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    bus_write(0, 3, 2, 32'd20);
    bus_read(0, 3, 0, 32'h0, "period_write_stops_run");
    bus_write(0, 3, 3, 32'd0);
    bus_read(0, 3, 3, 32'd20, "period_force_reload");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, g; string n;
    bus_write(0, 3, 1, 32'h7);
    repeat (25) @(posedge clk);
    #1;
    total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got=%b want=1", irq_a); end
    reset_n = 1'b0;
    #2;
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got=%b want=0", irq_a); end
    total++; if (irqv_a !== 4'd0) begin bad++; $display("FAIL mid_reset_irq_vec: got=%b want=0000", irqv_a); end
    total++; if (rd_a !== 32'd0) begin bad++; $display("FAIL mid_reset_readdata: got=%h want=0", rd_a); end
    #1;
    reset_n = 1'b1;
    bus_read(0, 3, 0, 32'h0, "post_reset_status");
    bus_read(0, 3, 1, 32'h0, "post_reset_control");
    bus_read(0, 3, 2, 32'd499, "post_reset_period");
    bus_read(0, 3, 3, 32'd0, "post_reset_snap");
    repeat (5) @(posedge clk);
    #1;
    bus_write(0, 3, 3, 32'd0);
    bus_read(0, 3, 3, 32'd499, "post_reset_counter");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_wrap8();
    logic [31:0] e, g; string n; int clks;
    bus_write(1, 0, 2, 32'hFF);
    bus_write(1, 0, 1, 32'h7);
    clks = 0;
    while (clks < 400 && irqv_b[0] !== 1'b1) begin
      @(posedge clk); #1; clks++;
    end
    total++; if (clks != 257) begin bad++; $display("FAIL wrap8_first_irq: clocks=%0d want=257", clks); end
    bus_write(1, 0, 0, 32'd0);
    clks = 258;
    do begin
      @(posedge clk); #1; clks++;
    end while (clks < 700 && irqv_b[0] !== 1'b1);
    total++; if (clks != 513) begin bad++; $display("FAIL wrap8_second_irq: clocks=%0d want=513", clks); end
    bus_read(1, 0, 2, 32'h0000_00FF, "wrap8_period_readback");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s: got=%h want=%h", n, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_one_shot();
    test_prescale();
    test_start_stop_period();
    test_reset_mid();
    test_wrap8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
